fc_weight_reader: RTL and testbench

FC_WEIGHT_READER -- requirements
Module: fc_weight_reader

---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_skid_fifo.sv | 45 ++++
 rtl/fc_weight_reader.sv | 162 ++++++++++++++++
 tb/tb_fc_weight_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and defaults for the FC weight reader.
package fc_pkg;

  localparam int unsigned FC_ADDR_W     = 9;
  localparam int unsigned FC_DATA_W     = 16;
  localparam int unsigned FC_MAX_PAIRS  = 256;
  localparam int unsigned FC_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } fc_state_e;

endpackage

// File: rtl/fc_skid_fifo.sv
// Two-entry skid FIFO holding ROM pairs between the read pipeline and the consumer.
module fc_skid_fifo
  import fc_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * FC_DATA_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [FC_FIFO_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fc_weight_reader.sv
// Streams word pairs from a dual-port ROM through a credit-limited skid FIFO.
// Optional FC_READER_CHECKSUM_EN adds a running checksum of accepted pairs.
module fc_weight_reader
  import fc_pkg::*;
#(
  parameter int unsigned ADDR_W = FC_ADDR_W,
  parameter int unsigned DATA_W = FC_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_pairs,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef FC_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int unsigned FifoW = 2 * DATA_W + 1;

  fc_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_iss_cnt;
  logic              r_primed;
  logic              r_rd_v;
  logic              r_rd_last;
  logic              r_busy;
  logic              r_done;

  logic              w_pop;
  logic              w_issue;
  logic              w_credit;
  logic              w_fifo_valid;
  logic [1:0]        w_fifo_count;
  logic [FifoW-1:0]  w_push_data;
  logic [FifoW-1:0]  w_head;
  logic [ADDR_W-1:0] w_num;

  assign w_num = (num_pairs > ADDR_W'(FC_MAX_PAIRS)) ? ADDR_W'(FC_MAX_PAIRS) : num_pairs;
  assign w_pop = w_fifo_valid & out_ready;

  // A slot freed by this cycle's pop can be reused by the read issued now.
  assign w_credit = ({1'b0, w_fifo_count} + {2'b00, r_rd_v}) < (3'd2 + {2'b00, w_pop});
  assign w_issue  = (r_state == StRun) && r_primed && (r_iss_cnt != '0) && w_credit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_iss_cnt <= '0;
      r_primed  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_addr    <= base_addr;
            r_iss_cnt <= w_num;
            r_primed  <= 1'b0;
            r_busy    <= 1'b1;
            if (w_num == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          // One settling cycle so the first ROM sample sees the loaded base address.
          r_primed <= 1'b1;
          if (w_issue) begin
            r_addr    <= r_addr + ADDR_W'(2);
            r_iss_cnt <= r_iss_cnt - ADDR_W'(1);
            if (r_iss_cnt == ADDR_W'(1)) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (w_pop && out_last) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // The ROM samples r_addr on the issue edge; its data appears on q_a/q_b one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_v    <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_v <= w_issue;
      if (w_issue) begin
        r_rd_last <= (r_iss_cnt == ADDR_W'(1));
      end
    end
  end

  assign w_push_data = {r_rd_last, q_a, q_b};

  fc_skid_fifo #(
    .WIDTH (FifoW)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (r_rd_v),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

`ifdef FC_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + out_a + out_b;
    end
  end

  assign checksum = r_checksum;
`endif

  assign address_a = r_addr;
  assign address_b = r_addr + ADDR_W'(1);
  assign out_valid = w_fifo_valid;
  assign out_last  = w_head[FifoW-1];
  assign out_a     = w_head[2*DATA_W-1:DATA_W];
  assign out_b     = w_head[DATA_W-1:0];
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fc_weight_reader.sv
// Scoreboard bench for fc_weight_reader with a rom[i]=i model and randomized back-pressure.
module tb_fc_weight_reader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int ROM_WORDS = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_pairs = '0;
  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef FC_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  fc_weight_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_pairs (num_pairs),
    .address_a (address_a),
    .address_b (address_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef FC_READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clock = ~clock;

  // ROM with rom[i] = i and one cycle of read latency.
  always_ff @(posedge clock) begin
    q_a <= DATA_W'(address_a);
    q_b <= DATA_W'(address_b);
  end

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int accepted = 0;
  int rdy_mode = 0;
  logic [2*DATA_W:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Back-pressure driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        1:       out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks holds while stalled.
  initial begin
    logic              prev_stall;
    logic [2*DATA_W:0] prev_data;
    logic [2*DATA_W:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold_valid", 64'(out_valid), 64'd1);
          chk("stall_hold_data", 64'({out_last, out_a, out_b}), 64'(prev_data));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pair", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("pair", 64'({out_last, out_a, out_b}), 64'(e));
            accepted++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = {out_last, out_a, out_b};
        if (done) begin
          done_cnt++;
          chk("done_after_last_pair", 64'(exp_q.size()), 64'd0);
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_address_a", 64'(address_a), 64'd0);
    chk("rst_address_b", 64'(address_b), 64'd1);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
  endtask

  task automatic push_expected(input int base, input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      a = (base + 2 * k) % ROM_WORDS;
      exp_q.push_back({(k == n - 1), DATA_W'(a), DATA_W'((a + 1) % ROM_WORDS)});
    end
  endtask

  task automatic run_burst(input int base, input int n, input bit check_lat);
    int edges;
    int d0;
    push_expected(base, n);
    d0 = done_cnt;
    base_addr = ADDR_W'(base);
    num_pairs = ADDR_W'(n);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (check_lat) begin
      edges = 0;
      while (!out_valid && edges < 10) begin
        @(posedge clock);
        #1;
        edges++;
      end
      chk("first_valid_latency", 64'(edges), 64'd3);
      chk("busy_in_burst", 64'(busy), 64'd1);
      // A start while busy must not disturb the burst.
      base_addr = ADDR_W'(300);
      num_pairs = ADDR_W'(5);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    for (int c = 0; c < 3000 && done_cnt == d0; c++) @(posedge clock);
    chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    chk("all_pairs_accepted", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Basic burst with full-rate consumer.
    rdy_mode = 0;
    run_burst(0, 4, 1'b1);
`ifdef FC_READER_CHECKSUM_EN
    chk("checksum_4", 64'(checksum), 64'd28);
`endif

    // Address wrap at the top of the ROM.
    run_burst(510, 2, 1'b0);

    // Stalling consumer.
    rdy_mode = 1;
    run_burst(40, 8, 1'b0);
    rdy_mode = 0;

    // Empty burst: done one cycle after start, and a start during DONE is ignored.
    d0 = done_cnt;
    base_addr = ADDR_W'(7);
    num_pairs = '0;
    start = 1'b1;
    @(posedge clock);
    #1;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_no_valid", 64'(out_valid), 64'd0);
    base_addr = ADDR_W'(100);
    num_pairs = ADDR_W'(3);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("zero_done_drop", 64'(done), 64'd0);
    chk("zero_busy_drop", 64'(busy), 64'd0);
    repeat (8) @(posedge clock);
    #1;
    chk("zero_ignored_start_valid", 64'(out_valid), 64'd0);
    chk("zero_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset after two accepted pairs of six.
    accepted = 0;
    push_expected(20, 6);
    base_addr = ADDR_W'(20);
    num_pairs = ADDR_W'(6);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int c = 0; c < 50 && accepted < 2; c++) begin
      @(negedge clock);
      #1;
    end
    chk("reset_mid_accepted", 64'(accepted), 64'd2);
    reset = 1'b1;
    #1;
    check_reset_vals();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("no_stale_after_reset", 64'(out_valid), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);

`ifdef FC_READER_CHECKSUM_EN
    run_burst(0, 2, 1'b0);
    chk("checksum_2", 64'(checksum), 64'd6);
`endif

    // Randomized bursts under random back-pressure, including the maximum length.
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) begin
      run_burst(int'($urandom_range(0, ROM_WORDS - 1)), int'($urandom_range(1, 24)), 1'b0);
    end
    run_burst(int'($urandom_range(0, ROM_WORDS - 1)), 256, 1'b0);
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
